// File: rtl/bloom_ast_pkg.sv
// -----------------------------------------------------------------------------
// bloom_ast_pkg
// Shared types and width helpers for the Avalon-ST word reassembly path.
//   ast_rx_state_t : receive FSM states (IDLE, COLLECT, DROP, HOLD)
//   ast_empty_w()  : width of the AST empty field for a given beat width
//   ast_ptr_w()    : width of the symbol pointer / length field
// -----------------------------------------------------------------------------
package bloom_ast_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DROP    = 2'd2,
        HOLD    = 2'd3
    } ast_rx_state_t;

    // A one-symbol beat still carries a 1-bit empty field so the port exists.
    function automatic int ast_empty_w(input int symbols);
        return (symbols == 1) ? 1 : $clog2(symbols);
    endfunction

    // One extra bit so the pointer can represent DATA_SYMBOLS itself.
    function automatic int ast_ptr_w(input int data_symbols);
        return $clog2(data_symbols) + 1;
    endfunction

endpackage

// File: rtl/ast_lane_unpack.sv
// -----------------------------------------------------------------------------
// ast_lane_unpack
// Combinational lane normaliser for one AST beat.
//   data_i      : raw beat data, SYMBOLS lanes of BYTE_W bits
//   empty_i     : empty symbol count, honoured only when eop_i is set
//   eop_i       : end-of-packet flag of the beat
//   lane_data_o : logical lanes; lane i carries the i-th symbol of the beat
//   lane_vld_o  : per-lane valid mask (contiguous from lane 0)
//   lane_cnt_o  : number of valid lanes
// ORDER=1 means the first symbol sits in the most significant lane.
// -----------------------------------------------------------------------------
module ast_lane_unpack #(
    parameter int BYTE_W  = 8,
    parameter int SYMBOLS = 1,
    parameter int ORDER   = 1,
    parameter int EMPTY_W = 1,
    parameter int CNT_W   = 1
) (
    input  logic [SYMBOLS*BYTE_W-1:0] data_i,
    input  logic [EMPTY_W-1:0]        empty_i,
    input  logic                      eop_i,
    output logic [SYMBOLS*BYTE_W-1:0] lane_data_o,
    output logic [SYMBOLS-1:0]        lane_vld_o,
    output logic [CNT_W-1:0]          lane_cnt_o
);

    genvar gi;
    generate
        for (gi = 0; gi < SYMBOLS; gi++) begin : g_lane
            if (ORDER != 0) begin : g_rev
                assign lane_data_o[gi*BYTE_W +: BYTE_W] = data_i[(SYMBOLS-1-gi)*BYTE_W +: BYTE_W];
            end else begin : g_fwd
                assign lane_data_o[gi*BYTE_W +: BYTE_W] = data_i[gi*BYTE_W +: BYTE_W];
            end
            // Trailing lanes of the EOP beat are empty; all other beats are full.
            assign lane_vld_o[gi] = !eop_i || ((gi + int'(empty_i)) < SYMBOLS);
        end
    endgenerate

    always_comb begin : cnt_proc
        int n;
        n = 0;
        for (int i = 0; i < SYMBOLS; i++) begin
            if (lane_vld_o[i]) begin
                n = n + 1;
            end
        end
        lane_cnt_o = CNT_W'(n);
    end

endmodule

// File: rtl/ast_to_data.sv
// -----------------------------------------------------------------------------
// ast_to_data
// Avalon-ST sink that reassembles one packet of DATA_SYMBOLS symbols into a
// parallel word for the bloom hash/query stage, flagging malformed packets
// (short, long, missing SOP, restart with a new SOP).
// Ports:
//   clk_i, srst_i            : clock, synchronous active-high reset
//   ast_sink_*               : AST sink (data/valid/ready/empty/sop/eop)
//   data_o                   : assembled word, symbol k at [k*BYTE_W +: BYTE_W]
//   data_valid_o/data_ready_i: word handshake; word held until accepted
//   data_len_o               : symbols stored (saturates at DATA_SYMBOLS)
//   data_err_o               : word came from a malformed packet
// Optional build macro AST_TO_DATA_STATS_EN adds pkt_cnt_o / err_cnt_o.
// -----------------------------------------------------------------------------
module ast_to_data
    import bloom_ast_pkg::*;
#(
    parameter int BYTE_W           = 8,
    parameter int DATA_SYMBOLS     = 6,
    parameter int AST_SINK_SYMBOLS = 1,
    parameter int AST_SINK_ORDER   = 1,
    parameter int AST_SINK_EMPTY_W = ast_empty_w(AST_SINK_SYMBOLS)
) (
    input  logic                                 clk_i,
    input  logic                                 srst_i,
    input  logic [AST_SINK_SYMBOLS*BYTE_W-1:0]   ast_sink_data_i,
    input  logic                                 ast_sink_valid_i,
    output logic                                 ast_sink_ready_o,
    input  logic [AST_SINK_EMPTY_W-1:0]          ast_sink_empty_i,
    input  logic                                 ast_sink_startofpacket_i,
    input  logic                                 ast_sink_endofpacket_i,
    output logic [DATA_SYMBOLS*BYTE_W-1:0]       data_o,
    output logic                                 data_valid_o,
    input  logic                                 data_ready_i,
    output logic [$clog2(DATA_SYMBOLS):0]        data_len_o,
    output logic                                 data_err_o
`ifdef AST_TO_DATA_STATS_EN
    ,
    output logic [31:0]                          pkt_cnt_o,
    output logic [15:0]                          err_cnt_o
`endif
);

    localparam int PTR_W  = ast_ptr_w(DATA_SYMBOLS);
    localparam int CNT_W  = $clog2(AST_SINK_SYMBOLS + 1);
    localparam int WORD_W = DATA_SYMBOLS * BYTE_W;

    ast_rx_state_t            state_q, state_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [WORD_W-1:0]        word_q, word_d;
    logic                     err_pend_q, err_pend_d;
    logic                     err_q, err_d;

    logic [AST_SINK_SYMBOLS*BYTE_W-1:0] lane_data;
    logic [AST_SINK_SYMBOLS-1:0]        lane_vld;
    logic [CNT_W-1:0]                   lane_cnt;

    logic beat_acc;
    logic handshake;
    logic orphan_evt;

    ast_lane_unpack #(
        .BYTE_W  (BYTE_W),
        .SYMBOLS (AST_SINK_SYMBOLS),
        .ORDER   (AST_SINK_ORDER),
        .EMPTY_W (AST_SINK_EMPTY_W),
        .CNT_W   (CNT_W)
    ) u_unpack (
        .data_i      (ast_sink_data_i),
        .empty_i     (ast_sink_empty_i),
        .eop_i       (ast_sink_endofpacket_i),
        .lane_data_o (lane_data),
        .lane_vld_o  (lane_vld),
        .lane_cnt_o  (lane_cnt)
    );

    assign ast_sink_ready_o = !srst_i && (state_q != HOLD);
    assign beat_acc         = ast_sink_valid_i && ast_sink_ready_o;
    assign handshake        = (state_q == HOLD) && data_ready_i && !srst_i;

    always_comb begin : fsm_comb
        int  base_v;
        int  sum_v;
        logic pend_v;
        state_d    = state_q;
        ptr_d      = ptr_q;
        word_d     = word_q;
        err_pend_d = err_pend_q;
        err_d      = err_q;
        orphan_evt = 1'b0;
        base_v     = 0;
        sum_v      = 0;
        pend_v     = 1'b0;

        case (state_q)
            IDLE, COLLECT: begin
                if (beat_acc) begin
                    if ((state_q == IDLE) && !ast_sink_startofpacket_i) begin
                        // Packet without SOP: nothing to keep.
                        if (ast_sink_endofpacket_i) begin
                            orphan_evt = 1'b1;
                        end else begin
                            err_pend_d = 1'b1;
                            state_d    = DROP;
                        end
                    end else begin
                        // Any SOP (first or restart) starts a fresh, zeroed word.
                        if (ast_sink_startofpacket_i) begin
                            base_v = 0;
                            word_d = '0;
                        end else begin
                            base_v = int'(ptr_q);
                        end
                        for (int k = 0; k < DATA_SYMBOLS; k++) begin
                            for (int i = 0; i < AST_SINK_SYMBOLS; i++) begin
                                if (lane_vld[i] && ((base_v + i) == k)) begin
                                    word_d[k*BYTE_W +: BYTE_W] = lane_data[i*BYTE_W +: BYTE_W];
                                end
                            end
                        end
                        // Integer sum cannot wrap; ptr saturates at DATA_SYMBOLS.
                        sum_v  = base_v + int'(lane_cnt);
                        pend_v = err_pend_q ||
                                 (ast_sink_startofpacket_i && (state_q == COLLECT));
                        ptr_d  = (sum_v >= DATA_SYMBOLS) ? PTR_W'(DATA_SYMBOLS) : PTR_W'(sum_v);
                        if (ast_sink_endofpacket_i) begin
                            state_d    = HOLD;
                            err_pend_d = pend_v;
                            err_d      = pend_v || (sum_v != DATA_SYMBOLS);
                        end else if (sum_v >= DATA_SYMBOLS) begin
                            state_d    = DROP;
                            err_pend_d = 1'b1;
                        end else begin
                            state_d    = COLLECT;
                            err_pend_d = pend_v;
                        end
                    end
                end
            end
            DROP: begin
                if (beat_acc && ast_sink_endofpacket_i) begin
                    if (ptr_q != '0) begin
                        state_d = HOLD;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        orphan_evt = 1'b1;
                        err_pend_d = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (data_ready_i) begin
                    state_d    = IDLE;
                    err_pend_d = 1'b0;
                    err_d      = 1'b0;
                    ptr_d      = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            word_q     <= '0;
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            word_q     <= word_d;
            err_pend_q <= err_pend_d;
            err_q      <= err_d;
        end
    end

    // Valid is masked during reset so a held word never escapes.
    assign data_valid_o = (state_q == HOLD) && !srst_i;
    assign data_o       = word_q;
    assign data_len_o   = ptr_q;
    assign data_err_o   = err_q;

`ifdef AST_TO_DATA_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        err_cnt_d = err_cnt_q;
        if (handshake) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
        if (((handshake && err_q) || orphan_evt) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pkt_cnt_o = pkt_cnt_q;
    assign err_cnt_o = err_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = handshake ^ orphan_evt;
`endif

endmodule

// File: tb/tb_ast_to_data.sv
// -----------------------------------------------------------------------------
// tb_ast_to_data
// Directed bench for ast_to_data: one single-symbol-beat instance (ORDER=1)
// and two four-symbol-beat instances (ORDER=1 and ORDER=0) fed the same
// packets in their respective lane orders.
// -----------------------------------------------------------------------------
module tb_ast_to_data;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Single-symbol-beat instance
    logic [7:0]  a_data;
    logic        a_valid, a_ready, a_sop, a_eop, a_rdy, a_dv, a_err;
    logic [0:0]  a_empty;
    logic [47:0] a_word;
    logic [3:0]  a_len;

    // Four-symbol-beat instances; shared control, separate data packing
    logic [31:0] b_data, c_data;
    logic        b_valid, b_sop, b_eop, b_rdy;
    logic [1:0]  b_empty;
    logic        b_ready, c_ready, b_dv, c_dv, b_err, c_err;
    logic [47:0] b_word, c_word;
    logic [3:0]  b_len, c_len;

    ast_to_data #(.BYTE_W(8), .DATA_SYMBOLS(6), .AST_SINK_SYMBOLS(1), .AST_SINK_ORDER(1)) dut_a (
        .clk_i(clk), .srst_i(srst),
        .ast_sink_data_i(a_data), .ast_sink_valid_i(a_valid), .ast_sink_ready_o(a_ready),
        .ast_sink_empty_i(a_empty), .ast_sink_startofpacket_i(a_sop), .ast_sink_endofpacket_i(a_eop),
        .data_o(a_word), .data_valid_o(a_dv), .data_ready_i(a_rdy),
        .data_len_o(a_len), .data_err_o(a_err)
    );

    ast_to_data #(.BYTE_W(8), .DATA_SYMBOLS(6), .AST_SINK_SYMBOLS(4), .AST_SINK_ORDER(1)) dut_b (
        .clk_i(clk), .srst_i(srst),
        .ast_sink_data_i(b_data), .ast_sink_valid_i(b_valid), .ast_sink_ready_o(b_ready),
        .ast_sink_empty_i(b_empty), .ast_sink_startofpacket_i(b_sop), .ast_sink_endofpacket_i(b_eop),
        .data_o(b_word), .data_valid_o(b_dv), .data_ready_i(b_rdy),
        .data_len_o(b_len), .data_err_o(b_err)
    );

    ast_to_data #(.BYTE_W(8), .DATA_SYMBOLS(6), .AST_SINK_SYMBOLS(4), .AST_SINK_ORDER(0)) dut_c (
        .clk_i(clk), .srst_i(srst),
        .ast_sink_data_i(c_data), .ast_sink_valid_i(b_valid), .ast_sink_ready_o(c_ready),
        .ast_sink_empty_i(b_empty), .ast_sink_startofpacket_i(b_sop), .ast_sink_endofpacket_i(b_eop),
        .data_o(c_word), .data_valid_o(c_dv), .data_ready_i(b_rdy),
        .data_len_o(c_len), .data_err_o(c_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic a_beat(input logic [7:0] d, input logic sop, input logic eop);
        a_data = d; a_valid = 1'b1; a_sop = sop; a_eop = eop;
        @(posedge clk); #1;
        a_valid = 1'b0; a_sop = 1'b0; a_eop = 1'b0;
    endtask

    // n beats first, first+1, ...; SOP on the first, EOP on the last.
    task automatic a_pkt(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            a_beat(first + 8'(i), i == 0, i == n - 1);
        end
    endtask

    task automatic a_take();
        a_rdy = 1'b1;
        @(posedge clk); #1;
        a_rdy = 1'b0;
    endtask

    task automatic b_beat(input logic [31:0] db, input logic [31:0] dc,
                          input logic sop, input logic eop, input logic [1:0] emp);
        b_data = db; c_data = dc; b_valid = 1'b1; b_sop = sop; b_eop = eop; b_empty = emp;
        @(posedge clk); #1;
        b_valid = 1'b0; b_sop = 1'b0; b_eop = 1'b0; b_empty = 2'd0;
    endtask

    task automatic b_take();
        b_rdy = 1'b1;
        @(posedge clk); #1;
        b_rdy = 1'b0;
    endtask

    logic [7:0]  sym [6];
    logic [47:0] exp_word;

    initial begin
        srst = 1'b1;
        a_data = '0; a_valid = 0; a_sop = 0; a_eop = 0; a_rdy = 0; a_empty = '0;
        b_data = '0; c_data = '0; b_valid = 0; b_sop = 0; b_eop = 0; b_rdy = 0; b_empty = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", a_ready, 0);
        chk("rst_valid", a_dv, 0);
        chk("rst_len", a_len, 0);
        chk("rst_data", a_word, 0);
        chk("rst_err", a_err, 0);
        srst = 1'b0;
        #1;
        chk("post_rst_ready", a_ready, 1);

        // Basic 6-beat packet
        for (int i = 0; i < 5; i++) a_beat(8'(i + 1), i == 0, 1'b0);
        chk("t1_valid_before_eop", a_dv, 0);
        a_beat(8'h06, 1'b0, 1'b1);
        chk("t1_valid", a_dv, 1);
        chk("t1_data", a_word, 48'h060504030201);
        chk("t1_len", a_len, 6);
        chk("t1_err", a_err, 0);
        chk("t1_ready_hold", a_ready, 0);
        a_take();
        chk("t1_valid_after", a_dv, 0);
        chk("t1_ready_after", a_ready, 1);

        // Four-symbol beats, both lane orders
        b_beat(32'h01020304, 32'h04030201, 1'b1, 1'b0, 2'd0);
        chk("t2_valid_mid", b_dv, 0);
        b_beat(32'h0506AAAA, 32'hAAAA0605, 1'b0, 1'b1, 2'd2);
        chk("t2_b_valid", b_dv, 1);
        chk("t2_b_data", b_word, 48'h060504030201);
        chk("t2_b_err", b_err, 0);
        chk("t2_b_len", b_len, 6);
        chk("t2_c_data", c_word, 48'h060504030201);
        chk("t2_c_err", c_err, 0);
        b_take();
        chk("t2_b_valid_after", b_dv, 0);

        // Back-pressure: word held stable for 10 cycles
        a_pkt(8'h41, 6);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("t3_ready_low", a_ready, 0);
            chk("t3_word_stable", a_word, 48'h464544434241);
        end
        chk("t3_valid_held", a_dv, 1);
        a_take();
        chk("t3_ready_back", a_ready, 1);
        a_pkt(8'h51, 6);
        chk("t3_next_valid", a_dv, 1);
        chk("t3_next_data", a_word, 48'h565554535251);
        a_take();

        // Short and long packets
        a_pkt(8'h01, 4);
        chk("t4s_valid", a_dv, 1);
        chk("t4s_len", a_len, 4);
        chk("t4s_err", a_err, 1);
        chk("t4s_data", a_word, 48'h000004030201);
        a_take();
        for (int i = 0; i < 7; i++) begin
            a_beat(8'h11 + 8'(i), i == 0, 1'b0);
            if (i == 6) chk("t4l_ready_drop", a_ready, 1);
        end
        chk("t4l_valid_before_eop", a_dv, 0);
        a_beat(8'h18, 1'b0, 1'b1);
        chk("t4l_valid", a_dv, 1);
        chk("t4l_len", a_len, 6);
        chk("t4l_err", a_err, 1);
        chk("t4l_data", a_word, 48'h161514131211);
        a_take();

        // Orphan beat and SOP restart
        a_beat(8'h77, 1'b0, 1'b1);
        chk("t5o_valid", a_dv, 0);
        chk("t5o_ready", a_ready, 1);
        @(posedge clk); #1;
        chk("t5o_valid_later", a_dv, 0);
        a_beat(8'h01, 1'b1, 1'b0);
        a_beat(8'h02, 1'b0, 1'b0);
        a_pkt(8'h21, 6);
        chk("t5r_valid", a_dv, 1);
        chk("t5r_data", a_word, 48'h262524232221);
        chk("t5r_err", a_err, 1);
        chk("t5r_len", a_len, 6);
        a_take();

        // Reset mid-packet
        a_beat(8'h01, 1'b1, 1'b0);
        a_beat(8'h02, 1'b0, 1'b0);
        srst = 1'b1;
        #1;
        chk("t6m_ready_in_rst", a_ready, 0);
        @(posedge clk); #1;
        srst = 1'b0;
        chk("t6m_len", a_len, 0);
        chk("t6m_data", a_word, 0);
        for (int i = 0; i < 4; i++) a_beat(8'h03 + 8'(i), 1'b0, i == 3);
        chk("t6m_no_valid", a_dv, 0);
        a_pkt(8'h31, 6);
        chk("t6m_clean_valid", a_dv, 1);
        chk("t6m_clean_data", a_word, 48'h363534333231);
        chk("t6m_clean_err", a_err, 0);

        // Reset while holding a word
        srst = 1'b1;
        #1;
        chk("t6h_valid_in_rst", a_dv, 0);
        @(posedge clk); #1;
        srst = 1'b0;
        chk("t6h_valid_after", a_dv, 0);
        chk("t6h_data_after", a_word, 0);
        a_pkt(8'h61, 6);
        chk("t6h_clean_data", a_word, 48'h666564636261);
        chk("t6h_clean_len", a_len, 6);
        a_take();

        // Random packets with idle gaps and consumer stalls on both lane orders
        for (int p = 0; p < 8; p++) begin
            for (int k = 0; k < 6; k++) sym[k] = 8'($urandom);
            exp_word = {sym[5], sym[4], sym[3], sym[2], sym[1], sym[0]};
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            b_beat({sym[0], sym[1], sym[2], sym[3]}, {sym[3], sym[2], sym[1], sym[0]},
                   1'b1, 1'b0, 2'd0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            b_beat({sym[4], sym[5], 16'h5A5A}, {16'hA5A5, sym[5], sym[4]}, 1'b0, 1'b1, 2'd2);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            chk("rnd_b_valid", b_dv, 1);
            chk("rnd_b_data", b_word, exp_word);
            chk("rnd_c_data", c_word, exp_word);
            chk("rnd_c_err", c_err, 0);
            b_take();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
